// File: rtl/adder_checker.sv
// adder_checker: exhaustive sweep driver and result checker for a WIDTH-bit adder with LATENCY-cycle response.
// Define ADDER_CHECKER_FIRSTFAIL_EN to add fail_a_o/fail_b_o/fail_valid_o first-mismatch capture.
module adder_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
  output logic [WIDTH-1:0] fail_a_o,
  output logic [WIDTH-1:0] fail_b_o,
  output logic             fail_valid_o,
`endif
  output logic [15:0]      err_count_o
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = WIDTH + 1;
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
  localparam int DW = 1 + EW + VW;
`else
  localparam int DW = 1 + EW;
`endif
  localparam logic [2:0] LAST_DRAIN = 3'(LATENCY > 0 ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [2:0]    drain_q, drain_d;
  logic [15:0]   err_q, err_d;
  logic          start_acc;
  logic          mismatch;
  logic [EW-1:0] exp_now;
  logic [DW-1:0] dl_in, dl_out;

  assign a_o     = vec_q[VW-1:WIDTH];
  assign b_o     = vec_q[WIDTH-1:0];
  assign exp_now = {1'b0, a_o} + {1'b0, b_o};

  // Delay-line entry: {valid, expected {carry,sum}} plus the operands when first-fail capture is built.
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
  assign dl_in = {state_q == DRIVE, exp_now, vec_q};
`else
  assign dl_in = {state_q == DRIVE, exp_now};
`endif

  if (LATENCY == 0) begin : g_nodelay
    assign dl_out = dl_in;
  end else begin : g_delay
    logic [DW-1:0] pipe_q [LATENCY];
    always_ff @(posedge clk_i) begin
      if (!rst_n_i || start_acc) begin
        for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= dl_in;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign dl_out = pipe_q[LATENCY-1];
  end

  assign mismatch = dl_out[DW-1] && ({carry_i, sum_i} != dl_out[DW-2 -: EW]);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    drain_d   = drain_q;
    err_d     = err_q;
    start_acc = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = DRIVE;
          vec_d     = '0;
        end
      end
      DRIVE: begin
        if (vec_q == '1) begin
          drain_d = '0;
          state_d = (LATENCY > 0) ? DRAIN : DONE;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (start_acc)                             err_d = '0;
    else if (mismatch && err_q != 16'hFFFF)    err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      vec_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q == DRIVE) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign pass_o      = (state_q == DONE) && (err_q == 16'd0);
  assign err_count_o = err_q;

`ifdef ADDER_CHECKER_FIRSTFAIL_EN
  logic [VW-1:0] fail_vec_q, fail_vec_d;
  logic          fail_valid_q, fail_valid_d;

  always_comb begin
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    if (start_acc) begin
      fail_vec_d   = '0;
      fail_valid_d = 1'b0;
    end else if (mismatch && !fail_valid_q) begin
      fail_vec_d   = dl_out[VW-1:0];
      fail_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign fail_a_o     = fail_vec_q[VW-1:WIDTH];
  assign fail_b_o     = fail_vec_q[WIDTH-1:0];
  assign fail_valid_o = fail_valid_q;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Scoreboard bench: a 1-bit zero-latency checker and a 2-bit two-cycle checker, each facing a bench-side adder with injectable faults.
module tb_adder_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic        rst1_n, start1, a1, b1, sum1, carry1, busy1, done1, pass1;
  logic [15:0] err1;
  logic        rst2_n, start2, carry2, busy2, done2, pass2;
  logic [1:0]  a2, b2, sum2;
  logic [15:0] err2;
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
  logic        fa1, fb1, fv1, fv2;
  logic [1:0]  fa2, fb2;
`endif

  logic [1:0] fault1 [4];
  logic [2:0] fault2 [16];
  bit         stuck1;
  int         lat2;
  logic [2:0] p0, p1;

  typedef struct {int err; int pass; int done_cyc; int busy; int fa; int fb; int fv;} exp_t;
  exp_t q1[$];
  exp_t q2[$];

  adder_checker #(.WIDTH(1), .LATENCY(0)) u1 (
    .clk_i(clk), .rst_n_i(rst1_n), .start_i(start1), .a_o(a1), .b_o(b1),
    .sum_i(sum1), .carry_i(carry1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
    .fail_a_o(fa1), .fail_b_o(fb1), .fail_valid_o(fv1),
`endif
    .err_count_o(err1)
  );

  adder_checker #(.WIDTH(2), .LATENCY(2)) u2 (
    .clk_i(clk), .rst_n_i(rst2_n), .start_i(start2), .a_o(a2), .b_o(b2),
    .sum_i(sum2), .carry_i(carry2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
    .fail_a_o(fa2), .fail_b_o(fb2), .fail_valid_o(fv2),
`endif
    .err_count_o(err2)
  );

  // Adders under test: true a+b with an XOR fault mask per operand vector.
  function automatic logic [1:0] f1(int v);
    logic [1:0] r;
    r = 2'((v >> 1) + (v & 1)) ^ fault1[v];
    if (stuck1) r[1] = 1'b0;
    return r;
  endfunction

  function automatic logic [2:0] f2(int v);
    return 3'((v >> 2) + (v & 3)) ^ fault2[v];
  endfunction

  always_comb {carry1, sum1} = f1(int'({a1, b1}));

  always @(posedge clk) begin
    p0 <= f2(int'({a2, b2}));
    p1 <= p0;
  end
  assign {carry2, sum2} = (lat2 == 2) ? p1 : p0;

  // Reference: vector k is judged against whatever the adder returns `shift` vectors later (clamped at the last one).
  function automatic exp_t model(int w, int lat, int shift, int s, bit second);
    exp_t e;
    int n, v, got, want, m;
    n = 1 << (2 * w);
    m = (1 << w) - 1;
    e = '{0, 0, s + n + lat, n + lat, 0, 0, 0};
    for (int k = 0; k < n; k++) begin
      v    = (k + shift < n) ? k + shift : n - 1;
      got  = second ? int'(f2(v)) : int'(f1(v));
      want = (k >> w) + (k & m);
      if (got != want) begin
        if (e.fv == 0) begin
          e.fa = k >> w;
          e.fb = k & m;
          e.fv = 1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic cmp(string tag, exp_t e, int err, int pass, int bc);
    chk({tag, "_err_count"}, err, e.err);
    chk({tag, "_pass"}, pass, e.pass);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_busy_cycles"}, bc, e.busy);
  endtask

  int   idx1 = 0, bc1 = 0, idx2 = 0, bc2 = 0;
  logic pd1 = 1'b0, pd2 = 1'b0;

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst1_n) begin
      idx1 = 0; bc1 = 0; pd1 = 1'b0;
    end else begin
      if (busy1) begin
        chk("dut1_ab", int'({a1, b1}), (idx1 < 4) ? idx1 : 3);
        idx1++; bc1++;
      end
      if (done1 && !pd1) begin
        if (q1.size() == 0) chk("dut1_sb_entries", q1.size(), 1);
        else begin
          e = q1.pop_front();
          cmp("dut1", e, int'(err1), int'(pass1), bc1);
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
          chk("dut1_fail_a", int'(fa1), e.fa);
          chk("dut1_fail_b", int'(fb1), e.fb);
          chk("dut1_fail_valid", int'(fv1), e.fv);
`endif
        end
        idx1 = 0; bc1 = 0;
      end
      pd1 = done1;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst2_n) begin
      idx2 = 0; bc2 = 0; pd2 = 1'b0;
    end else begin
      if (busy2) begin
        chk("dut2_ab", int'({a2, b2}), (idx2 < 16) ? idx2 : 15);
        idx2++; bc2++;
      end
      if (done2 && !pd2) begin
        if (q2.size() == 0) chk("dut2_sb_entries", q2.size(), 1);
        else begin
          e = q2.pop_front();
          cmp("dut2", e, int'(err2), int'(pass2), bc2);
`ifdef ADDER_CHECKER_FIRSTFAIL_EN
          chk("dut2_fail_a", int'(fa2), e.fa);
          chk("dut2_fail_b", int'(fb2), e.fb);
          chk("dut2_fail_valid", int'(fv2), e.fv);
`endif
        end
        idx2 = 0; bc2 = 0;
      end
      pd2 = done2;
    end
  end

  task automatic go1();
    @(negedge clk);
    q1.push_back(model(1, 0, 0, cyc + 1, 1'b0));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("dut1_done_drop", int'(done1), 0);
  endtask

  task automatic go2(bit score);
    @(negedge clk);
    if (score) q2.push_back(model(2, 2, 2 - lat2, cyc + 1, 1'b1));
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("dut2_done_drop", int'(done2), 0);
  endtask

  task automatic wait1();
    for (int i = 0; i < 200; i++) begin
      if (done1) break;
      @(negedge clk);
    end
    chk("dut1_done_timeout", int'(done1), 1);
  endtask

  task automatic wait2();
    for (int i = 0; i < 200; i++) begin
      if (done2) break;
      @(negedge clk);
    end
    chk("dut2_done_timeout", int'(done2), 1);
  endtask

  task automatic clear_faults();
    foreach (fault1[i]) fault1[i] = 2'd0;
    foreach (fault2[i]) fault2[i] = 3'd0;
    stuck1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    lat2 = 2;
    clear_faults();
    repeat (3) @(negedge clk);
    chk("rst_a1", int'(a1), 0);       chk("rst_b1", int'(b1), 0);
    chk("rst_busy1", int'(busy1), 0); chk("rst_done1", int'(done1), 0);
    chk("rst_pass1", int'(pass1), 0); chk("rst_err1", int'(err1), 0);
    chk("rst_a2", int'(a2), 0);       chk("rst_b2", int'(b2), 0);
    chk("rst_busy2", int'(busy2), 0); chk("rst_done2", int'(done2), 0);
    chk("rst_pass2", int'(pass2), 0); chk("rst_err2", int'(err2), 0);
    rst1_n = 1'b1; rst2_n = 1'b1;

    // Half adder: clean, carry stuck at 0, then random fault masks (restarts from DONE).
    go1(); wait1();
    stuck1 = 1'b1;
    go1(); wait1();
    stuck1 = 1'b0;
    for (int s = 0; s < 6; s++) begin
      foreach (fault1[i]) fault1[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      go1(); wait1();
    end
    clear_faults();

    // 2-bit, two-cycle: clean, adder actually one cycle, then random latency and faults.
    go2(1'b1); wait2();
    lat2 = 1;
    go2(1'b1); wait2();
    for (int s = 0; s < 6; s++) begin
      lat2 = $urandom_range(1, 2);
      foreach (fault2[i]) fault2[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      go2(1'b1); wait2();
    end
    lat2 = 2;
    clear_faults();

    // Extra start in cycle 3 of a sweep must not disturb it.
    go2(1'b1);
    @(negedge clk);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait2();

    // Reset in cycle 2 aborts the sweep; a fresh start then runs clean.
    go2(1'b0);
    @(negedge clk);
    rst2_n = 1'b0;
    @(negedge clk);
    chk("abort_a2", int'(a2), 0);       chk("abort_b2", int'(b2), 0);
    chk("abort_busy2", int'(busy2), 0); chk("abort_done2", int'(done2), 0);
    chk("abort_err2", int'(err2), 0);
    @(negedge clk);
    rst2_n = 1'b1;
    go2(1'b1); wait2();

    @(negedge clk);
    chk("dut1_sb_leftover", q1.size(), 0);
    chk("dut2_sb_leftover", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adder_checker.md
# adder_checker

Self-checking stimulus/response engine for the adder cells (half adder and wider ripple variants). It drives every operand combination exhaustively into an adder under test and collects the returned sum/carry. Each result is compared against an internally computed reference, and the block reports error count, pass/fail and done. It sits opposite the adder under test: it owns the adder's inputs and consumes its outputs, replacing the open-loop stimulus-only driver.

## Interface
- `WIDTH`, default 1: operand width in bits. Range 1–8; WIDTH=1 checks a half adder.
- `LATENCY`, default 0: adder-under-test latency in clock cycles, from a/b change to valid sum/carry. Range 0–7.
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising clk.
- `start`  in  1  single-cycle request to begin a full sweep.
- `a`  out  WIDTH  operand A to the adder under test (registered).
- `b`  out  WIDTH  operand B to the adder under test (registered).
- `sum`  in  WIDTH  sum returned by the adder under test.
- `carry`  in  1  carry returned by the adder under test.
- `busy`  out  1  high in DRIVE or DRAIN.
- `done`  out  1  high in DONE; held until the next accepted start or reset.
- `pass`  out  1  valid only while done=1; equals (err_count == 0).
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.

## Operation
- Reference model: the expected {carry,sum} is a+b computed at WIDTH+1 bits. sum is the low WIDTH bits; carry is bit WIDTH.
- Vector counter `vec`, 2*WIDTH bits wide, drives {a,b} = vec. a is the upper half. Sweep order is 0 to 2^(2*WIDTH)−1.
- A delay line LATENCY stages deep carries {valid, expected}. For LATENCY=0 the expected value comes directly from the current a,b registers.
- Compare in every cycle where the delayed valid is 1. A mismatch on either sum or carry increments err_count by 1, or holds it at saturation.
- FSM states:
  - IDLE: outputs idle. start → DRIVE; this clears vec, err_count and the delay line, and loads a=b=0.
  - DRIVE: vec increments each cycle. After the vector with vec all-ones is driven: go to DRAIN if LATENCY>0, else DONE.
  - DRAIN: wait exactly LATENCY cycles while the last results are compared; a and b hold the final vector. Then → DONE.
  - DONE: done=1. start → DRIVE, with the same clearing as from IDLE.
- start is ignored in DRIVE and DRAIN.
- Any cycle with rst_n=0 forces IDLE and clears everything, including during a sweep. Partial results are discarded.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, state=IDLE.
- Cycle numbering: let N = 2^(2*WIDTH), and let start be sampled high at edge 0.
- a,b show vector k during cycle k+1, for k = 0..N−1. busy is high from cycle 1 to cycle N+LATENCY.
- The result for vector k is sampled at the end of cycle k+1+LATENCY.
- done and pass rise in cycle N+LATENCY+1. err_count is final in the same cycle.
- err_count updates one cycle after the compare cycle. The update for the final compare lands in the same edge that enters DONE.
- Restart from DONE: the first new vector appears in the cycle after start is sampled, and done drops in that same cycle.

## Configuration
- `ADDER_CHECKER_FIRSTFAIL_EN`
- When defined, the block adds these outputs:
  - `fail_a` (WIDTH), `fail_b` (WIDTH): operands of the first mismatching vector.
  - `fail_valid` (1): set when that first mismatch is captured.
- These outputs hold their values until the next start or reset; reset value is 0.
- When not defined, none of these ports or registers exist; behaviour is otherwise identical.

## Test plan
- WIDTH=1, LATENCY=0, correct half adder, start at edge 0. Required: a,b sequence 00,01,10,11 in cycles 1–4; done=1 in cycle 5; pass=1; err_count=0.
- WIDTH=1, LATENCY=0, carry stuck at 0. Required: err_count=1, pass=0; with the macro, fail_a=1, fail_b=1, fail_valid=1.
- WIDTH=2, LATENCY=2, registered 2-bit adder behind a 2-stage pipe. Required: 16 vectors; busy high in cycles 1–18; done in cycle 19; pass=1.
- WIDTH=2, LATENCY=2, DUT LATENCY actually 1 (mis-set parameter). Required: err_count nonzero, pass=0.
- start pulsed again in cycle 3 of a sweep. Required: ignored; done still arrives in cycle N+LATENCY+1.
- rst_n low in cycle 2 mid-sweep. Required: next cycle a=b=0, busy=0, err_count=0, state IDLE. A new start then gives a full clean pass.
